blk_53af6d: RTL and testbench
=============================

SUB_TOP_NIOS2_QSYS_0_JTAG_DEBUG_MODULE_VJI_MASTER -- requirements
Module: sub_top_nios2_qsys_0_jtag_debug_module_vji_master

Interface
REQ-001 SHALL have parameter SR_WIDTH, default 38, giving the DR scan length in bits.
REQ-002 SHALL have parameter IR_WIDTH, default 2, giving the virtual IR width.
REQ-003 SHALL have parameter TCK_DIV, default 2, giving clk cycles per TCK half-period; legal values are 1 to 255.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port cmd_valid, input, 1 bit: a scan command is offered.
REQ-008 SHALL have port cmd_ready, output, 1 bit: the block accepts a command.
REQ-009 SHALL have port cmd_ir, input, IR_WIDTH bits: the virtual IR value for the scan.
REQ-010 SHALL have port cmd_wdata, input, SR_WIDTH bits: the DR data shifted out on TDI, LSB first.
REQ-011 SHALL have port rsp_valid, output, 1 bit: a one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata, output, SR_WIDTH bits: the DR data captured from TDO.
REQ-013 SHALL have port rsp_ir_out, output, IR_WIDTH bits: the vji_ir_out value captured during UIR.
REQ-014 SHALL have port vji_tck, output, 1 bit: the generated TCK.
REQ-015 SHALL have port vji_tdi, output, 1 bit: serial data to the target.
REQ-016 SHALL have port vji_tdo, input, 1 bit: serial data from the target.
REQ-017 SHALL have port vji_ir_in, output, IR_WIDTH bits: the IR value presented to the target.
REQ-018 SHALL have port vji_ir_out, input, IR_WIDTH bits: the IR status from the target.
REQ-019 SHALL have ports vji_uir, vji_cdr, vji_sdr, vji_udr and vji_rti, each an output of 1 bit: the virtual TAP state strobes.

Function
REQ-020 SHALL implement FSM states IDLE, UIR, CDR, SDR, UDR, RTI and RSP.
REQ-021 SHALL assert cmd_ready only in IDLE; the accept condition is cmd_valid and cmd_ready on a rising clk edge.
REQ-022 SHALL, on accept, latch cmd_ir into vji_ir_in and cmd_wdata into the shift register, and enter UIR.
REQ-023 SHALL ignore cmd_valid in every state except IDLE, without corrupting the scan in progress.
REQ-024 SHALL define one TCK period as 2*TCK_DIV clk cycles, with vji_tck low for the first TCK_DIV cycles and high for the last TCK_DIV cycles.
REQ-025 SHALL hold vji_tck low in IDLE and RSP.
REQ-026 SHALL change FSM state, the strobes and vji_tdi only at the start of a TCK period, while TCK is low.
REQ-027 SHALL hold each of UIR, CDR, UDR and RTI for exactly 1 TCK period.
REQ-028 SHALL hold SDR for exactly SR_WIDTH TCK periods.
REQ-029 SHALL assert exactly one strobe per active state: vji_uir in UIR, vji_cdr in CDR, vji_sdr in SDR, vji_udr in UDR, vji_rti in RTI.
REQ-030 SHALL drive vji_tdi from shift register bit 0 during SDR, and drive vji_tdi to 0 in all other states.
REQ-031 SHALL, on each clk cycle in which vji_tck goes from 0 to 1 during SDR, shift the register right and load vji_tdo into bit SR_WIDTH-1.
REQ-032 SHALL capture vji_ir_out into rsp_ir_out on the TCK rising edge of UIR.
REQ-033 SHALL use a bit counter of width clog2(SR_WIDTH+1) that terminates SDR after exactly SR_WIDTH rising edges; there are no extra or missing shifts.
REQ-034 SHALL, in RSP, drive rsp_valid high for exactly 1 clk cycle with rsp_rdata equal to the shift register, then return to IDLE.
REQ-035 SHALL hold rsp_rdata and rsp_ir_out stable until the next rsp_valid.
REQ-036 SHALL assert rsp_valid exactly (SR_WIDTH+4)*2*TCK_DIV+1 cycles after the accept cycle; this is 169 cycles with the default parameters.
REQ-037 SHALL make a back-to-back command accepted in IDLE on the cycle after rsp_valid start a new UIR period with no TCK glitch.
REQ-038 SHALL roll the TCK divider counter over cleanly at TCK_DIV-1; with TCK_DIV=1, TCK toggles every clk cycle.

Reset
REQ-039 SHALL, while reset is high, force the FSM to IDLE.
REQ-040 SHALL, while reset is high, force cmd_ready=0, vji_tck=0, vji_tdi=0, all strobes to 0, vji_ir_in=0, rsp_valid=0, rsp_rdata=0, rsp_ir_out=0 and all counters to 0.
REQ-041 SHALL set cmd_ready to 1 on the first clk edge after reset deasserts.
REQ-042 SHALL, when reset occurs mid-scan, abort the scan immediately with no rsp_valid and no UDR strobe.

Verification
REQ-043 SHALL cover a loopback test: vji_tdo tied to a 1-scan-delayed vji_tdi, cmd_ir=2'b01, cmd_wdata=38'h2A_5A5A_5A5A -> rsp_valid 169 cycles after accept, vji_ir_in=2'b01, exactly 38 TCK rising edges with vji_sdr=1.
REQ-044 SHALL cover a TDO pattern test: vji_tdo driven with the bit sequence 1,0,0,...,0,1 (38 bits, first bit shifted in first) -> rsp_rdata=38'h20_0000_0001.
REQ-045 SHALL cover IR status capture: vji_ir_out=2'b10 during UIR, 2'b00 otherwise -> rsp_ir_out=2'b10.
REQ-046 SHALL cover a busy command: cmd_valid held high through the scan with changing cmd_wdata -> only one accept per scan, the second scan uses data present on the cycle after rsp_valid, and vji_tck stays low in RSP.
REQ-047 SHALL cover reset mid-scan: reset pulsed at bit 10 of SDR -> all outputs 0 within the reset cycle, no rsp_valid, cmd_ready=1 one cycle after release.
REQ-048 SHALL cover TCK_DIV=1: the default scan -> TCK period of 2 clk cycles, rsp_valid 85 cycles after accept.

Source files
------------

// File: rtl/blk_53af6d.sv
// Virtual JTAG scan master: turns one command into a full UIR/CDR/SDR/UDR/RTI
// sequence on a divided TCK and returns the captured DR and IR status.
`timescale 1ns/1ps
module blk_53af6d #(
  parameter int SR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_wdata,
  output logic                rsp_valid,
  output logic [SR_WIDTH-1:0] rsp_rdata,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int CW = $clog2(SR_WIDTH + 1);
  localparam int DW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(SR_WIDTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(TCK_DIV - 1);

  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, RSP} state_t;

  state_t              state, state_next;
  logic [DW-1:0]       div_cnt;
  logic                phase;
  logic [CW-1:0]       bit_cnt;
  logic [SR_WIDTH-1:0] shreg;
  logic                tdi_q;
  logic                init_done;
  logic [IR_WIDTH-1:0] ir_in_q;
  logic [IR_WIDTH-1:0] ir_cap;
  logic [IR_WIDTH-1:0] ir_rsp;
  logic [SR_WIDTH-1:0] rdata_q;

  logic active, div_last, tck_rise, period_end, accept;

  assign active     = (state == UIR) || (state == CDR) || (state == SDR) ||
                      (state == UDR) || (state == RTI);
  assign div_last   = (div_cnt == DIV_LAST);
  assign tck_rise   = active && !phase && div_last;
  assign period_end = active && phase && div_last;
  assign cmd_ready  = init_done && (state == IDLE);
  assign accept     = cmd_valid && cmd_ready;

  assign vji_tck    = phase;
  assign vji_tdi    = tdi_q;
  assign vji_ir_in  = ir_in_q;
  assign vji_uir    = (state == UIR);
  assign vji_cdr    = (state == CDR);
  assign vji_sdr    = (state == SDR);
  assign vji_udr    = (state == UDR);
  assign vji_rti    = (state == RTI);
  assign rsp_valid  = (state == RSP);
  assign rsp_rdata  = rdata_q;
  assign rsp_ir_out = ir_rsp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // States only advance on the last clk of a TCK period so every change lands
  // at the start of the next period while TCK is low.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept)     state_next = UIR;
      UIR:  if (period_end) state_next = CDR;
      CDR:  if (period_end) state_next = SDR;
      SDR:  if (period_end && (bit_cnt == BIT_LAST)) state_next = UDR;
      UDR:  if (period_end) state_next = RTI;
      RTI:  if (period_end) state_next = RSP;
      RSP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_done <= 1'b0;
      div_cnt   <= '0;
      phase     <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      tdi_q     <= 1'b0;
      ir_in_q   <= '0;
      ir_cap    <= '0;
      ir_rsp    <= '0;
      rdata_q   <= '0;
    end else begin
      init_done <= 1'b1;

      if (active) begin
        if (div_last) begin
          div_cnt <= '0;
          phase   <= ~phase;
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end else begin
        div_cnt <= '0;
        phase   <= 1'b0;
      end

      if (accept) begin
        shreg   <= cmd_wdata;
        ir_in_q <= cmd_ir;
        bit_cnt <= '0;
      end

      if (tck_rise && (state == SDR)) begin
        shreg   <= SR_WIDTH'({vji_tdo, shreg} >> 1);
        bit_cnt <= bit_cnt + CW'(1);
      end

      if (tck_rise && (state == UIR))
        ir_cap <= vji_ir_out;

      // The shift already happened on this period's rising edge, so bit 0 is
      // the next bit to present for the whole following period.
      if (period_end)
        tdi_q <= (state_next == SDR) ? shreg[0] : 1'b0;

      if (period_end && (state == RTI)) begin
        rdata_q <= shreg;
        ir_rsp  <= ir_cap;
      end
    end
  end

endmodule

// File: tb/tb_blk_53af6d.sv
// Scoreboard bench for blk_53af6d: random scans, loopback, TDO pattern, busy
// command, mid-scan reset and a TCK_DIV=1 instance.
`timescale 1ns/1ps
module tb_blk_53af6d;
  localparam int SR  = 38;
  localparam int IRW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic           cmd_valid, cmd_ready;
  logic [IRW-1:0] cmd_ir;
  logic [SR-1:0]  cmd_wdata;
  logic           rsp_valid;
  logic [SR-1:0]  rsp_rdata;
  logic [IRW-1:0] rsp_ir_out;
  logic           vji_tck, vji_tdi, vji_tdo;
  logic [IRW-1:0] vji_ir_in, vji_ir_out;
  logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  logic           cmd_valid1, cmd_ready1;
  logic [IRW-1:0] cmd_ir1;
  logic [SR-1:0]  cmd_wdata1;
  logic           rsp_valid1;
  logic [SR-1:0]  rsp_rdata1;
  logic [IRW-1:0] rsp_ir_out1;
  logic           vji_tck1, vji_tdi1;
  logic [IRW-1:0] vji_ir_in1;
  logic           uir1, cdr1, sdr1, udr1, rti1;

  blk_53af6d #(.SR_WIDTH(SR), .IR_WIDTH(IRW), .TCK_DIV(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_ir_out(rsp_ir_out), .vji_tck(vji_tck),
    .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
    .vji_ir_out(vji_ir_out), .vji_uir(vji_uir), .vji_cdr(vji_cdr),
    .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti));

  // Second instance: same-scan loopback (tdo = tdi) with the fastest TCK.
  blk_53af6d #(.SR_WIDTH(SR), .IR_WIDTH(IRW), .TCK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_ir(cmd_ir1), .cmd_wdata(cmd_wdata1), .rsp_valid(rsp_valid1),
    .rsp_rdata(rsp_rdata1), .rsp_ir_out(rsp_ir_out1), .vji_tck(vji_tck1),
    .vji_tdi(vji_tdi1), .vji_tdo(vji_tdi1), .vji_ir_in(vji_ir_in1),
    .vji_ir_out(2'b00), .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1),
    .vji_udr(udr1), .vji_rti(rti1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [SR-1:0]  wdata;
    logic [SR-1:0]  tdo;
    logic [IRW-1:0] ir;
    logic [IRW-1:0] stat;
    int             acc;
  } exp_t;

  exp_t           q[$];
  exp_t           e_mon;
  logic [SR-1:0]  cur_tdo  = '0;
  logic [IRW-1:0] cur_stat = '0;
  logic [SR-1:0]  tdi_seen = '0;
  int             rsp_count = 0;
  int             bitidx    = SR;
  logic           prev_tck  = 1'b0;
  logic           prev_uir  = 1'b0;

  assign vji_ir_out = vji_uir ? cur_stat : 2'b00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: models the target side (tdo stream, tdi capture) and scores responses.
  always @(negedge clk) begin
    if (vji_tck && !prev_tck && vji_sdr) begin
      if (bitidx < SR) tdi_seen[bitidx] = vji_tdi;
      bitidx++;
    end
    prev_tck = vji_tck;
    if (vji_uir && !prev_uir) begin
      bitidx = 0;
      if (q.size() > 0) check("ir_in", 64'(vji_ir_in), 64'(q[0].ir));
    end
    prev_uir = vji_uir;
    vji_tdo = (bitidx < SR) ? cur_tdo[bitidx] : 1'b0;
    if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) > 1)
      check("strobe_onehot", 64'($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti})), 64'd1);
    if (rsp_valid) begin
      rsp_count++;
      if (q.size() == 0) begin
        check("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e_mon = q.pop_front();
        check("rsp_rdata",   64'(rsp_rdata),   64'(e_mon.tdo));
        check("rsp_ir_out",  64'(rsp_ir_out),  64'(e_mon.stat));
        check("tdi_stream",  64'(tdi_seen),    64'(e_mon.wdata));
        check("latency",     64'(cyc - e_mon.acc), 64'(169));
        check("sdr_rises",   64'(bitidx),      64'(SR));
        check("tck_low_rsp", 64'(vji_tck),     64'd0);
        $display("scan rsp: rdata=%h ir_out=%h latency=%0d", rsp_rdata, rsp_ir_out, cyc - e_mon.acc);
      end
    end
  end

  function automatic logic [SR-1:0] rnd_sr();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[SR-1:0];
  endfunction

  task automatic run_scan(input bit push, input logic [IRW-1:0] ir, input logic [SR-1:0] w,
                          input logic [SR-1:0] tdo, input logic [IRW-1:0] stat);
    int k;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ir = ir; cmd_wdata = w;
    k = 0;
    while (!cmd_ready && k < 500) begin @(negedge clk); k++; end
    if (!cmd_ready) begin
      check("ready_timeout", 64'd0, 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    cur_tdo = tdo; cur_stat = stat;
    if (push) q.push_back('{w, tdo, ir, stat, cyc});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int k;
    k = 0;
    while (rsp_count < target && k < 1000) begin @(negedge clk); k++; end
    check("rsp_arrived", 64'(rsp_count), 64'(target));
  endtask

  initial begin
    logic [SR-1:0]  w, prev_w, tdo_v;
    logic [IRW-1:0] ir_v, st_v;
    int k, acc_n, target, acc_cyc, rises;
    logic prev1;

    reset = 1'b1; cmd_valid = 1'b0; cmd_ir = '0; cmd_wdata = '0; vji_tdo = 1'b0;
    cmd_valid1 = 1'b0; cmd_ir1 = '0; cmd_wdata1 = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", 64'({cmd_ready, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr,
                             vji_rti, vji_ir_in, rsp_valid, rsp_ir_out}), 64'd0);
    check("reset_rdata", 64'(rsp_rdata), 64'd0);
    reset = 1'b0;
    #1 check("ready_at_release", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("ready_after_release", 64'(cmd_ready), 64'd1);

    // Loopback: tdo replays the previous scan's tdi stream.
    prev_w = rnd_sr();
    w = 38'h2A_5A5A_5A5A;
    run_scan(1'b1, 2'b01, w, prev_w, 2'b00);
    wait_rsp(1);
    prev_w = w; w = rnd_sr();
    run_scan(1'b1, 2'b01, w, prev_w, 2'b11);
    wait_rsp(2);

    // TDO pattern 1,0,...,0,1 and IR status capture.
    run_scan(1'b1, 2'b10, rnd_sr(), 38'h20_0000_0001, 2'b10);
    wait_rsp(3);

    for (int i = 0; i < 4; i++) begin
      ir_v = IRW'($urandom()); st_v = IRW'($urandom());
      run_scan(1'b1, ir_v, rnd_sr(), rnd_sr(), st_v);
      wait_rsp(4 + i);
    end

    // Busy command: valid held high with data changing every cycle.
    target = rsp_count + 3;
    acc_n = 0; k = 0;
    while (acc_n < 3 && k < 3000) begin
      @(negedge clk);
      w = rnd_sr(); ir_v = IRW'($urandom());
      cmd_valid = 1'b1; cmd_wdata = w; cmd_ir = ir_v;
      if (cmd_ready) begin
        tdo_v = rnd_sr(); st_v = IRW'($urandom());
        cur_tdo = tdo_v; cur_stat = st_v;
        q.push_back('{w, tdo_v, ir_v, st_v, cyc});
        acc_n++;
      end
      k++;
    end
    check("busy_accepts", 64'(acc_n), 64'd3);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp(target);

    // Reset in the middle of SDR: the scan is dropped.
    target = rsp_count;
    run_scan(1'b0, 2'b11, rnd_sr(), rnd_sr(), 2'b01);
    k = 0;
    while (!(vji_sdr && bitidx == 10) && k < 500) begin @(negedge clk); k++; end
    check("reached_bit10", 64'(bitidx), 64'd10);
    reset = 1'b1;
    #1;
    check("midreset_outs", 64'({cmd_ready, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr,
                                vji_rti, vji_ir_in, rsp_valid, rsp_ir_out}), 64'd0);
    check("midreset_rdata", 64'(rsp_rdata), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("midreset_ready_release", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("midreset_ready", 64'(cmd_ready), 64'd1);
    repeat (200) @(negedge clk);
    check("midreset_no_rsp", 64'(rsp_count), 64'(target));

    run_scan(1'b1, 2'b01, rnd_sr(), rnd_sr(), 2'b10);
    wait_rsp(target + 1);

    // TCK_DIV=1 instance: same-scan loopback returns the written data.
    for (int i = 0; i < 2; i++) begin
      w = rnd_sr();
      @(negedge clk);
      cmd_valid1 = 1'b1; cmd_wdata1 = w; cmd_ir1 = 2'b01;
      k = 0;
      while (!cmd_ready1 && k < 100) begin @(negedge clk); k++; end
      acc_cyc = cyc;
      @(negedge clk);
      cmd_valid1 = 1'b0;
      rises = 0; prev1 = 1'b0; k = 0;
      while (!rsp_valid1 && k < 300) begin
        if (vji_tck1 && !prev1) rises++;
        prev1 = vji_tck1;
        @(negedge clk); k++;
      end
      check("div1_rsp_valid", 64'(rsp_valid1), 64'd1);
      check("div1_latency", 64'(cyc - acc_cyc), 64'd85);
      check("div1_tck_rises", 64'(rises), 64'(SR + 4));
      check("div1_rdata", 64'(rsp_rdata1), 64'(w));
      $display("div1 scan: rdata=%h latency=%0d rises=%0d", rsp_rdata1, cyc - acc_cyc, rises);
    end

    check("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
